// File: rtl/ch_tap_reader_pkg.sv
// Shared sound package: default channel geometry and tap-reader FSM states,
// also used alongside ch_memory.
package ch_tap_reader_pkg;

  localparam int unsigned SND_N = 20;
  localparam int unsigned SND_L = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } tap_state_e;

endpackage

// File: rtl/ch_tap_mux.sv
// Combinational N:1 selector picking one W-bit tap out of a flattened snapshot.
module ch_tap_mux #(
  parameter int unsigned N  = 20,
  parameter int unsigned W  = 11,
  parameter int unsigned IW = 5
) (
  input  logic [N*W-1:0] taps,
  input  logic [IW-1:0]  sel,
  output logic [W-1:0]   data
);

  always_comb begin
    data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == IW'(i)) begin
        data = taps[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/ch_tap_reader.sv
// Snapshots the channel delay line on start and streams every tap out over a
// valid/ready handshake, oldest-first or newest-first.
module ch_tap_reader
  import ch_tap_reader_pkg::*;
#(
  parameter int unsigned N            = SND_N,
  parameter int unsigned L            = SND_L,
  parameter bit          OLDEST_FIRST = 1'b1,
  localparam int unsigned W           = L + 1,
  localparam int unsigned IW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_clk,
  input  logic           reset_n,
  input  logic [N*W-1:0] tap_bus,
  input  logic           start,
  output logic [W-1:0]   out_data,
  output logic [IW-1:0]  out_idx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           busy,
  output logic           done
);

  localparam logic [IW-1:0] FIRST_IDX = OLDEST_FIRST ? IW'(N - 1) : '0;
  localparam logic [IW-1:0] FINAL_IDX = OLDEST_FIRST ? '0 : IW'(N - 1);

  tap_state_e     state_q, state_d;
  logic [N*W-1:0] snap_q, snap_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d  = tap_bus;
          idx_d   = FIRST_IDX;
          valid_d = 1'b1;
          last_d  = (FIRST_IDX == FINAL_IDX);
          busy_d  = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (valid_q && out_ready) begin
          if (idx_q == FINAL_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d  = OLDEST_FIRST ? idx_q - 1'b1 : idx_q + 1'b1;
            last_d = (idx_d == FINAL_IDX);
          end
        end
      end
      // busy stays high through the done cycle and drops on the way back to idle
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ch_tap_mux #(
    .N (N),
    .W (W),
    .IW(IW)
  ) u_tap_mux (
    .taps(snap_q),
    .sel (idx_q),
    .data(out_data)
  );

  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ch_tap_reader.sv
// Bench for ch_tap_reader: two instances (oldest-first and newest-first) share
// stimulus and are checked every cycle against a transfer-count model.
module tb_ch_tap_reader;

  localparam int unsigned N    = 20;
  localparam int unsigned L    = 10;
  localparam int unsigned W    = L + 1;
  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned MAXC = 400;
  localparam int unsigned VW   = 4 + IW + W;

  logic           clk_clk   = 1'b0;
  logic           reset_n   = 1'b1;
  logic           start     = 1'b0;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] tap_bus   = '0;

  logic [W-1:0]  a_data, b_data;
  logic [IW-1:0] a_idx, b_idx;
  logic          a_valid, a_last, a_busy, a_done;
  logic          b_valid, b_last, b_busy, b_done;

  always #5 clk_clk = ~clk_clk;

  int unsigned cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned tap_val[N];
  int unsigned snap[N];
  int unsigned last_start = 0;

  ch_tap_reader #(.N(N), .L(L), .OLDEST_FIRST(1'b1)) dut_a (
    .clk_clk(clk_clk), .reset_n(reset_n), .tap_bus(tap_bus), .start(start),
    .out_data(a_data), .out_idx(a_idx), .out_valid(a_valid), .out_ready(out_ready),
    .out_last(a_last), .busy(a_busy), .done(a_done)
  );

  ch_tap_reader #(.N(N), .L(L), .OLDEST_FIRST(1'b0)) dut_b (
    .clk_clk(clk_clk), .reset_n(reset_n), .tap_bus(tap_bus), .start(start),
    .out_data(b_data), .out_idx(b_idx), .out_valid(b_valid), .out_ready(out_ready),
    .out_last(b_last), .busy(b_busy), .done(b_done)
  );

  typedef struct {
    string       name;
    int unsigned mode;       // 0: tap i = i+1, 1: random, 2: alternating 0 / max
    logic [7:0]  rdy_mask;   // out_ready pattern, bit (c-1) mod rdy_len
    int unsigned rdy_len;
    bit          dirty;      // overwrite tap_bus with all ones after capture
    bit          mid_start;  // pulse start while streaming
    int unsigned rst_at;     // drop reset while this transfer is presented (0 = never)
    bit          chk_period; // frame follows a full-speed frame back to back
    int unsigned exp_xfers;
    bit          exp_done;
  } vec_t;

  function automatic logic [VW-1:0] pk(input logic v, input logic l, input logic d,
                                       input logic b, input logic [IW-1:0] idx,
                                       input logic [W-1:0] data);
    return {v, l, d, b, idx, data};
  endfunction

  task automatic check(input string tag, input string what, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp, input logic [VW-1:0] mask);
    n_checks++;
    if ((got & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s_%s: got {v,l,d,b,idx,data}=%h expected %h (mask %h) cycle %0d",
               tag, what, got, exp, mask, cyc);
    end
  endtask

  task automatic check_int(input string tag, input string what, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s_%s: got %0d expected %0d", tag, what, got, exp);
    end
  endtask

  task automatic load_taps(input int unsigned mode);
    for (int unsigned i = 0; i < N; i++) begin
      case (mode)
        0:       tap_val[i] = i + 1;
        1:       tap_val[i] = $urandom_range(0, (1 << W) - 1);
        default: tap_val[i] = (i % 2 != 0) ? (1 << W) - 1 : 0;
      endcase
      tap_bus[i*W +: W] = W'(tap_val[i]);
      snap[i] = tap_val[i];
    end
  endtask

  task automatic run_frame(input vec_t v);
    int unsigned k = 0, xa = 0, xb = 0, phase = 0;
    bit finished = 0, da = 0, db = 0;
    logic [VW-1:0] ea, eb, m;
    load_taps(v.mode);
    start     = 1'b1;
    out_ready = v.rdy_mask[0];
    if (v.chk_period) check_int(v.name, "period", int'(cyc - last_start), N + 2);
    last_start = cyc;
    for (int unsigned c = 1; c <= MAXC && !finished; c++) begin
      @(negedge clk_clk);
      start = v.mid_start && (c == 5);
      if (c == 1 && v.dirty) tap_bus = '1;
      out_ready = v.rdy_mask[(c - 1) % v.rdy_len];
      if (v.rst_at != 0 && k == v.rst_at - 1) begin
        reset_n = 1'b0;
        #1;
        check(v.name, "rst_a", pk(a_valid, a_last, a_done, a_busy, a_idx, a_data), '0, '1);
        check(v.name, "rst_b", pk(b_valid, b_last, b_done, b_busy, b_idx, b_data), '0, '1);
        repeat (2) begin
          @(negedge clk_clk);
          check(v.name, "rst_hold", pk(a_valid, a_last, a_done, a_busy, a_idx, a_data), '0, '1);
        end
        reset_n = 1'b1;
        repeat (3) begin
          @(negedge clk_clk);
          check(v.name, "no_restart_a", pk(a_valid, a_last, a_done, a_busy, a_idx, a_data), '0, '1);
          check(v.name, "no_restart_b", pk(b_valid, b_last, b_done, b_busy, b_idx, b_data), '0, '1);
        end
        finished = 1;
      end else begin
        if (k < N) begin
          ea = pk(1'b1, k == N - 1, 1'b0, 1'b1, IW'(N - 1 - k), W'(snap[N - 1 - k]));
          eb = pk(1'b1, k == N - 1, 1'b0, 1'b1, IW'(k), W'(snap[k]));
          m  = '1;
        end else if (phase == 0) begin
          ea = pk(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
          eb = ea;
          m  = pk(1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
          phase = 1;
        end else begin
          ea = '0;
          eb = '0;
          m  = pk(1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
          finished = 1;
        end
        check(v.name, "a", pk(a_valid, a_last, a_done, a_busy, a_idx, a_data), ea, m);
        check(v.name, "b", pk(b_valid, b_last, b_done, b_busy, b_idx, b_data), eb, m);
        if (a_done) da = 1;
        if (b_done) db = 1;
        if (a_valid && out_ready) xa++;
        if (b_valid && out_ready) xb++;
        if (k < N && out_ready) k++;
      end
    end
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: frame still open after %0d cycles, expected completion", v.name, MAXC);
    end
    check_int(v.name, "xfers_a", xa, v.exp_xfers);
    check_int(v.name, "xfers_b", xb, v.exp_xfers);
    check_int(v.name, "done_a", da, v.exp_done);
    check_int(v.name, "done_b", db, v.exp_done);
  endtask

  initial begin
    vec_t tbl[7];
    vec_t rv;
    tbl[0] = '{"ramp",        0, 8'h01,       1, 0, 0, 0,  0, N, 1};
    tbl[1] = '{"stall_1001",  0, 8'b00001001, 4, 0, 0, 0,  1, N, 1};
    tbl[2] = '{"snap_immune", 1, 8'h01,       1, 1, 1, 0,  0, N, 1};
    tbl[3] = '{"reset_mid",   0, 8'h01,       1, 0, 0, 10, 0, 9, 0};
    tbl[4] = '{"after_rst",   0, 8'h01,       1, 0, 0, 0,  0, N, 1};
    tbl[5] = '{"b2b",         2, 8'h01,       1, 0, 0, 0,  1, N, 1};
    tbl[6] = '{"stall_011",   1, 8'b00000110, 3, 0, 0, 0,  0, N, 1};

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    check("reset", "a", pk(a_valid, a_last, a_done, a_busy, a_idx, a_data), '0, '1);
    check("reset", "b", pk(b_valid, b_last, b_done, b_busy, b_idx, b_data), '0, '1);
    reset_n = 1'b1;
    @(negedge clk_clk);
    check("idle", "a", pk(a_valid, a_last, a_done, a_busy, a_idx, a_data), '0, '1);

    for (int unsigned i = 0; i < 7; i++) run_frame(tbl[i]);

    for (int unsigned r = 0; r < 8; r++) begin
      rv.name      = "random";
      rv.mode      = 1;
      rv.rdy_len   = $urandom_range(1, 8);
      rv.rdy_mask  = 8'($urandom_range(0, 255));
      rv.rdy_mask[$urandom_range(0, rv.rdy_len - 1)] = 1'b1;
      rv.dirty     = 1'($urandom_range(0, 1));
      rv.mid_start = 1'($urandom_range(0, 1));
      rv.rst_at    = 0;
      rv.chk_period = 0;
      rv.exp_xfers = N;
      rv.exp_done  = 1;
      run_frame(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ch_tap_reader.md
CH_TAP_READER -- requirements
Module: ch_tap_reader

Interface
REQ-001 The block SHALL have parameter N, default 20, giving the number of taps in the channel delay line.
REQ-002 The block SHALL have parameter L, default 10, giving the sample width; each stored tap is W = L+1 bits.
REQ-003 The block SHALL have parameter OLDEST_FIRST, default 1: 1 = stream tap N-1 down to 0; 0 = stream tap 0 up to N-1.
REQ-004 The block SHALL have port clk_clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port tap_bus, input, N*W bits, the flattened delay line; tap i occupies bits [i*W +: W], tap 0 newest.
REQ-007 The block SHALL have port start, input, 1 bit, a single-cycle request to snapshot and stream all taps.
REQ-008 The block SHALL have port out_data, output, W bits, the current tap value.
REQ-009 The block SHALL have port out_idx, output, clog2(N) bits, the tap index of out_data.
REQ-010 The block SHALL have port out_valid, output, 1 bit, high when out_data/out_idx are presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit, consumer accept.
REQ-012 The block SHALL have port out_last, output, 1 bit, high with out_valid on the final tap of a frame.
REQ-013 The block SHALL have port busy, output, 1 bit, high from snapshot until the frame completes.
REQ-014 The block SHALL have port done, output, 1 bit, a single-cycle pulse after the last transfer.

Function
REQ-015 The FSM SHALL have the states IDLE, STREAM and DONE.
REQ-016 In IDLE with start=1, the block SHALL capture all N taps of tap_bus into internal snapshot registers on that edge and enter STREAM.
REQ-017 out_valid SHALL rise on the cycle after start is sampled, presenting the first tap (N-1 if OLDEST_FIRST, else 0).
REQ-018 A transfer SHALL occur on each edge where out_valid && out_ready; the block SHALL then advance the index by one (down if OLDEST_FIRST, else up) on the following cycle.
REQ-019 While out_valid=1 && out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-020 The block SHALL not drop out_valid before the corresponding transfer.
REQ-021 out_last SHALL be high exactly while the final index (0 if OLDEST_FIRST, else N-1) is presented.
REQ-022 On the last transfer the block SHALL enter DONE, deassert out_valid, pulse done for one cycle, then return to IDLE.
REQ-023 busy SHALL be high in STREAM and DONE and low in IDLE.
REQ-024 start SHALL be ignored while busy; the snapshot SHALL be immune to tap_bus changes after capture.
REQ-025 Back-to-back frames: start sampled in the cycle after done SHALL be accepted, giving minimum frame period N+2 cycles with out_ready held high.
REQ-026 Data SHALL pass unmodified (no sign extension or truncation); out_idx SHALL never exceed N-1.

Reset
REQ-027 When reset_n=0, the block SHALL immediately and asynchronously force state=IDLE, out_valid=0, out_last=0, busy=0, done=0, out_data=0, out_idx=0, and snapshot=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first frame after release SHALL require a new start.

Structure
REQ-029 The FSM state enum and the default N/L values SHALL live in the shared sound package used with ch_memory.
REQ-030 One sub-module SHALL be used: ch_tap_mux, a combinational W-bit N:1 selector from the snapshot by index; counter and FSM SHALL remain in ch_tap_reader.

Verification
REQ-031 Taps i=0..19 loaded with value i+1, start, out_ready=1: the bench SHALL observe 20 transfers idx 19..0 with data 20..1, out_last only on idx 0, and done on the cycle after.
REQ-032 The scenario of REQ-031 run with OLDEST_FIRST=0 SHALL yield idx 0..19 with data 1..20.
REQ-033 out_ready toggling 1,0,0,1 repeatedly SHALL keep data stable during stalls, yield no lost or duplicated idx, and produce exactly 20 transfers.
REQ-034 Changing tap_bus to all 0x7FF the cycle after start SHALL leave the streamed data equal to the original snapshot, and a start pulsed mid-frame SHALL be ignored.
REQ-035 reset_n dropped at the 10th transfer SHALL bring out_valid and busy low immediately with no done; a following start SHALL stream a full 20-tap frame.
REQ-036 Start re-asserted on the cycle after done SHALL produce a second frame beginning N+2 cycles after the first start.
